// File: rtl/feedback.sv
// Tsetlin-machine feedback stage: one-cycle registered update of automaton
// states (Type I / Type II) and saturating clause weights.
module feedback #(
    parameter int CLAUSE_NUM   = 4,
    parameter int WEIGHT_WIDTH = 8,
    parameter int LITERAL_NUM  = 8,
    parameter int STATE_WIDTH  = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic                                is_positive_sample,
    input  logic [CLAUSE_NUM-1:0]               conjunction_result,
    input  logic [LITERAL_NUM-1:0]              actions,
    input  logic [LITERAL_NUM-1:0]              literals,
    input  logic [CLAUSE_NUM*WEIGHT_WIDTH-1:0]  weight_in,
    output logic [CLAUSE_NUM*WEIGHT_WIDTH-1:0]  weight_out,
    input  logic [LITERAL_NUM*STATE_WIDTH-1:0]  state_in,
    output logic [LITERAL_NUM*STATE_WIDTH-1:0]  state_out
);

    localparam logic [STATE_WIDTH-1:0]  STATE_MAX  = '1;
    localparam logic [WEIGHT_WIDTH-1:0] WEIGHT_MAX = {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};
    localparam logic [WEIGHT_WIDTH-1:0] WEIGHT_MIN = {1'b1, {(WEIGHT_WIDTH-1){1'b0}}};

    logic [LITERAL_NUM*STATE_WIDTH-1:0] state_next;
    logic [CLAUSE_NUM*WEIGHT_WIDTH-1:0] weight_next;

    // Type I rewards include-on-true and exclude-on-false; Type II inverts both.
    for (genvar i = 0; i < LITERAL_NUM; i++) begin : g_state
        logic [STATE_WIDTH-1:0] s;
        logic                   both_set;
        logic                   both_clr;
        logic                   step_up;
        logic                   step_down;

        assign s         = state_in[i*STATE_WIDTH +: STATE_WIDTH];
        assign both_set  = actions[i] & literals[i];
        assign both_clr  = ~actions[i] & ~literals[i];
        assign step_up   = is_positive_sample ? both_set : both_clr;
        assign step_down = is_positive_sample ? both_clr : both_set;

        always_comb begin
            // NOTE: default first so every path assigns the output and no latch is inferred.
            state_next[i*STATE_WIDTH +: STATE_WIDTH] = s;
            if (step_up && s != STATE_MAX)
                state_next[i*STATE_WIDTH +: STATE_WIDTH] = s + 1'b1;
            else if (step_down && s != '0)
                state_next[i*STATE_WIDTH +: STATE_WIDTH] = s - 1'b1;
        end
    end

    // Type I pushes the weight away from zero, Type II pulls it toward zero
    // (0 counts as non-negative, so it steps to -1).
    for (genvar j = 0; j < CLAUSE_NUM; j++) begin : g_weight
        logic [WEIGHT_WIDTH-1:0] w;
        logic                    negative;
        logic                    step_up;

        assign w        = weight_in[j*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        assign negative = w[WEIGHT_WIDTH-1];
        assign step_up  = is_positive_sample ? ~negative : negative;

        always_comb begin
            weight_next[j*WEIGHT_WIDTH +: WEIGHT_WIDTH] = w;
            if (conjunction_result[j]) begin
                if (step_up && w != WEIGHT_MAX)
                    weight_next[j*WEIGHT_WIDTH +: WEIGHT_WIDTH] = w + 1'b1;
                else if (!step_up && w != WEIGHT_MIN)
                    weight_next[j*WEIGHT_WIDTH +: WEIGHT_WIDTH] = w - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            state_out  <= '0;
            weight_out <= '0;
        end else if (en) begin
            state_out  <= state_next;
            weight_out <= weight_next;
        end
    end

endmodule

// File: tb/tb_feedback.sv
// Self-checking bench for feedback: directed vector table plus randomized
// vectors against a behavioural model, results checked through a scoreboard queue.
module tb_feedback;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic        is_positive_sample = 1'b0;
    logic [3:0]  conjunction_result = '0;
    logic [7:0]  actions  = '0;
    logic [7:0]  literals = '0;
    logic [31:0] weight_in = '0;
    logic [31:0] weight_out;
    logic [31:0] state_in = '0;
    logic [31:0] state_out;

    feedback #(
        .CLAUSE_NUM(4), .WEIGHT_WIDTH(8), .LITERAL_NUM(8), .STATE_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .is_positive_sample(is_positive_sample),
        .conjunction_result(conjunction_result),
        .actions(actions), .literals(literals),
        .weight_in(weight_in), .weight_out(weight_out),
        .state_in(state_in), .state_out(state_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        pos;
        logic [3:0]  cr;
        logic [7:0]  act;
        logic [7:0]  lit;
        logic [31:0] s_in;
        logic [31:0] w_in;
        logic [31:0] exp_s;
        logic [31:0] exp_w;
    } vec_t;

    typedef struct {
        logic [31:0] s;
        logic [31:0] w;
        int          id;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_miss = 0;
    logic [31:0] cur_s = '0;
    logic [31:0] cur_w = '0;

    // Reference model: integer arithmetic with explicit clamping.
    function automatic void model(input logic pos, input logic [7:0] act, input logic [7:0] lit,
                                  input logic [3:0] cr, input logic [31:0] s_in,
                                  input logic [31:0] w_in, output logic [31:0] s_out,
                                  output logic [31:0] w_out);
        for (int i = 0; i < 8; i++) begin
            int s;
            s = int'(s_in[i*4 +: 4]);
            if (act[i] == lit[i]) s = s + ((act[i] == pos) ? 1 : -1);
            if (s > 15) s = 15;
            if (s < 0) s = 0;
            s_out[i*4 +: 4] = 4'(s);
        end
        for (int j = 0; j < 4; j++) begin
            int w;
            w = int'(signed'(w_in[j*8 +: 8]));
            if (cr[j]) begin
                if (pos) w = (w >= 0) ? w + 1 : w - 1;
                else     w = (w >= 0) ? w - 1 : w + 1;
            end
            if (w > 127) w = 127;
            if (w < -128) w = -128;
            w_out[j*8 +: 8] = 8'(w);
        end
    endfunction

    task automatic check();
        exp_t e;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_miss++;
            $display("FAIL scoreboard_empty: no expected entry for vector %0d", n_vec);
            return;
        end
        e = sb_q.pop_front();
        if (state_out !== e.s) begin
            n_miss++;
            $display("FAIL vec%0d state_out: got %h expected %h", e.id, state_out, e.s);
        end
        if (weight_out !== e.w) begin
            n_miss++;
            $display("FAIL vec%0d weight_out: got %h expected %h", e.id, weight_out, e.w);
        end
    endtask

    task automatic apply(input vec_t v, input int id);
        @(negedge clk);
        rst = v.rst;
        en = v.en;
        is_positive_sample = v.pos;
        conjunction_result = v.cr;
        actions = v.act;
        literals = v.lit;
        state_in = v.s_in;
        weight_in = v.w_in;
        sb_q.push_back('{s: v.exp_s, w: v.exp_w, id: id});
        cur_s = v.exp_s;
        cur_w = v.exp_w;
        @(posedge clk);
        #1;
        check();
    endtask

    vec_t vecs[16];

    initial begin
        // rst, en, pos, cr, act, lit, s_in, w_in, exp_s, exp_w
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 4'hF, 8'hFF, 8'hFF, 32'h12345678, 32'h11223344, 32'h0, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 4'hF, 8'hFF, 8'hFF, 32'h12345678, 32'h11223344, 32'h0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 4'hA, 8'hAA, 8'hCC, 32'h33333333, 32'h00000000, 32'h43324332, 32'h01000100};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 4'h5, 8'hAA, 8'hCC, 32'h43324332, 32'h01000100, 32'h33333333, 32'h01FF01FF};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 4'hF, 8'hFF, 8'hFF, 32'h00000000, 32'h7F7F7F7F, 32'h33333333, 32'h01FF01FF};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'h3, 8'h0F, 8'hF0, 32'hABCDEF01, 32'h80808080, 32'h33333333, 32'h01FF01FF};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 4'hC, 8'h00, 8'h00, 32'hFFFFFFFF, 32'h01020304, 32'h33333333, 32'h01FF01FF};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 4'h0, 8'hFF, 8'hFF, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'h12345678};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 4'h0, 8'hFF, 8'hFF, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 4'h0, 8'h00, 8'h00, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 4'hF, 8'h00, 8'h00, 32'h00000000, 32'h807F807F, 32'h00000000, 32'h807F807F};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 4'hF, 8'h00, 8'h00, 32'h00000000, 32'h817F0080, 32'h11111111, 32'h827EFF81};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 4'hF, 8'h00, 8'h00, 32'hFFFFFFFF, 32'h817F00FF, 32'hEEEEEEEE, 32'h807F01FE};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 4'hF, 8'hFF, 8'hFF, 32'h55555555, 32'h10101010, 32'h00000000, 32'h00000000};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 4'hA, 8'hAA, 8'hCC, 32'h33333333, 32'h00000000, 32'h43324332, 32'h01000100};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};

        for (int k = 0; k < 16; k++) apply(vecs[k], k);

        // Randomized vectors; en=0 entries must leave the previous result in place.
        for (int k = 0; k < 60; k++) begin
            vec_t        v;
            logic [31:0] ms;
            logic [31:0] mw;
            v.rst  = 1'b0;
            v.en   = ($urandom_range(0, 3) != 0);
            v.pos  = 1'($urandom_range(0, 1));
            v.cr   = 4'($urandom);
            v.act  = 8'($urandom);
            v.lit  = 8'($urandom);
            v.s_in = $urandom;
            v.w_in = $urandom;
            if (k % 8 == 0) v.s_in = (k % 16 == 0) ? 32'hFFFFFFFF : 32'h00000000;
            if (k % 8 == 4) v.w_in = (k % 16 == 4) ? 32'h7F807F80 : 32'h80817F7E;
            model(v.pos, v.act, v.lit, v.cr, v.s_in, v.w_in, ms, mw);
            v.exp_s = v.en ? ms : cur_s;
            v.exp_w = v.en ? mw : cur_w;
            apply(v, 100 + k);
        end

        if (sb_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/feedback.md
FEEDBACK -- requirements
Module: feedback

Interface
REQ-001 The module SHALL have parameter CLAUSE_NUM, default 4, meaning the number of clauses (one weight each).
REQ-002 The module SHALL have parameter WEIGHT_WIDTH, default 8, meaning the bit width of each signed two's-complement clause weight.
REQ-003 The module SHALL have parameter LITERAL_NUM, default 8, meaning the number of literals (one automaton state each).
REQ-004 The module SHALL have parameter STATE_WIDTH, default 4, meaning the bit width of each unsigned automaton state.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on the rising edge only.
REQ-006 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The module SHALL have port en, input, 1 bit: update enable, sampled on the clock edge.
REQ-008 The module SHALL have port is_positive_sample, input, 1 bit: 1 selects Type I (positive) feedback, 0 selects Type II (negative) feedback.
REQ-009 The module SHALL have port conjunction_result, input, CLAUSE_NUM bits: bit j=1 means clause j matched.
REQ-010 The module SHALL have port actions, input, LITERAL_NUM bits: per-literal include action.
REQ-011 The module SHALL have port literals, input, LITERAL_NUM bits: per-literal input value.
REQ-012 The module SHALL have port weight_in, input, CLAUSE_NUM*WEIGHT_WIDTH bits: current weights, clause j at [j*WEIGHT_WIDTH +: WEIGHT_WIDTH].
REQ-013 The module SHALL have port weight_out, output, CLAUSE_NUM*WEIGHT_WIDTH bits: registered updated weights, same packing as weight_in.
REQ-014 The module SHALL have port state_in, input, LITERAL_NUM*STATE_WIDTH bits: current states, literal i at [i*STATE_WIDTH +: STATE_WIDTH].
REQ-015 The module SHALL have port state_out, output, LITERAL_NUM*STATE_WIDTH bits: registered updated states, same packing as state_in.

Function
REQ-016 On a rising edge with rst=0 and en=1, state_out and weight_out SHALL load values computed from the inputs sampled at that edge, i.e. one-cycle latency.
REQ-017 On a rising edge with rst=0 and en=0, both outputs SHALL hold their values.
REQ-018 The outputs SHALL be pure register outputs with no combinational path from the inputs.
REQ-019 Each state SHALL use literal i's own input only (a=actions[i], l=literals[i], s=state_in slice i, MAX=2^STATE_WIDTH-1); conjunction_result SHALL NOT affect states.
REQ-020 Type I state update: a=1,l=1 -> s+1 if s<MAX, else s; a=0,l=0 -> s-1 if s>0, else s; otherwise s.
REQ-021 Type II state update: a=1,l=1 -> s-1 if s>0, else s; a=0,l=0 -> s+1 if s<MAX, else s; otherwise s.
REQ-022 Each weight w_j (signed weight_in slice j) SHALL be held when conjunction_result[j]=0.
REQ-023 Type I weight update when matched: w>=0 -> w+1; w<0 -> w-1 (magnitude grows).
REQ-024 Type II weight update when matched: w>=0 -> w-1 (so 0 -> -1); w<0 -> w+1.
REQ-025 Weight arithmetic SHALL saturate: Type I at +2^(W-1)-1 holds, and at -2^(W-1) holds; no wrap-around in any case.
REQ-026 All literals and clauses SHALL update in parallel in the same cycle.

Reset
REQ-027 On a rising edge with rst=1, state_out and weight_out SHALL become all-zero regardless of en or other inputs, including mid-operation.
REQ-028 Update operation SHALL resume on the first edge with rst=0 and en=1.

Verification
REQ-029 Reset: rst=1 for one edge -> state_out=0, weight_out=0; with rst=1 and en=1 together, outputs SHALL still be 0.
REQ-030 Type I: all states 3, weights 0, actions=8'hAA, literals=8'hCC, conjunction_result=4'b1010, one en edge -> state_out=32'h43324332, weight_out=32'h01000100.
REQ-031 Type II chained: state_in=32'h43324332, weight_in=32'h01000100, same actions and literals, conjunction_result=4'b0101, one en edge -> state_out=32'h33333333, weight_out=32'h01FF01FF.
REQ-032 Hold: en=0 with changed inputs for several edges -> outputs unchanged.
REQ-033 State saturation: states at 15 under Type I with a=l=1 stay 15, and states at 0 under Type II with a=l=1 stay 0; states at 0 under Type I with a=l=0 stay 0.
REQ-034 Weight saturation: matched weight 8'h7F under Type I stays 7F, 8'h80 under Type I stays 80, 8'h81 under Type II becomes 82.
